// File: rtl/adsr_pkg.sv
// Shared types and level arithmetic for the ADSR envelope generator.
// Holds the state encoding, the field widths and the saturating step helpers.
package adsr_pkg;

  localparam int STATE_W = 3;
  localparam int LEVEL_W = 8;
  localparam int RATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  // A zero rate means "jump straight to the target" rather than "never move".
  function automatic logic [LEVEL_W-1:0] add_sat(input logic [LEVEL_W-1:0] lvl,
                                                 input logic [RATE_W-1:0]  rate);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, lvl} + {{(LEVEL_W-RATE_W+1){1'b0}}, rate};
    if (rate == '0 || sum[LEVEL_W]) return LEVEL_MAX;
    return sum[LEVEL_W-1:0];
  endfunction

  function automatic logic [LEVEL_W-1:0] sub_floor(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [RATE_W-1:0]  rate,
                                                   input logic [LEVEL_W-1:0] floor_lvl);
    logic [LEVEL_W:0] diff;
    diff = {1'b0, lvl} - {{(LEVEL_W-RATE_W+1){1'b0}}, rate};
    if (rate == '0 || diff[LEVEL_W] || diff[LEVEL_W-1:0] <= floor_lvl) return floor_lvl;
    return diff[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/adsr_env_if.sv
// Control/status bundle of the ADSR envelope: gate and rates in, level and state out.
// The controller drives through master; the envelope block sits on slave.
interface adsr_env_if;
  import adsr_pkg::*;

  logic                gate;
  logic [RATE_W-1:0]   attack_rate;
  logic [RATE_W-1:0]   decay_rate;
  logic [LEVEL_W-1:0]  sustain_lvl;
  logic [RATE_W-1:0]   release_rate;
  logic [LEVEL_W-1:0]  duty_cycle;
  logic [STATE_W-1:0]  env_state;
  logic                busy;

  modport master (
    output gate, attack_rate, decay_rate, sustain_lvl, release_rate,
    input  duty_cycle, env_state, busy
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_lvl, release_rate,
    output duty_cycle, env_state, busy
  );

endinterface

// File: rtl/adsr_tick.sv
// Free-running 8-bit PWM period counter plus a down-counting wrap divider that
// emits a one-cycle tick on every TICK_DIV-th 255->0 wrap.
module adsr_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] cnt,
  output logic       tick
);

  localparam logic [7:0] WRAP_LOAD = 8'(TICK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] wrap_q, wrap_d;
  logic       tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    wrap_d = wrap_q;
    tick_d = 1'b0;
    if (cnt_q == 8'hFF) begin
      if (wrap_q == 8'd0) begin
        tick_d = 1'b1;
        wrap_d = WRAP_LOAD;
      end else begin
        wrap_d = wrap_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      tick_q <= tick_d;
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope FSM; the level only moves on envelope ticks so duty_cycle is PWM-safe.
// Defining ADSR_ENV_PWM_EN adds the registered pwm_o output driven from the tick counter.
//
// state      | meaning
// IDLE       | note off, level parked at 0
// ATTACK     | ramping up toward 255
// DECAY      | ramping down toward sustain_lvl
// SUSTAIN    | holding sustain_lvl while gate is high
// RELEASE    | ramping down toward 0 after gate fell
module adsr_env
  import adsr_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  adsr_env_if.slave   env
`ifdef ADSR_ENV_PWM_EN
  ,
  output logic        pwm_o
`endif
);

  logic [7:0]         cnt;
  logic               tick;
  env_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               gate_q;
  logic               busy_q, busy_d;
  logic               rise, fall;

  adsr_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  // An accepted gate edge wins over a coincident tick, so that tick's level step is dropped.
  always_comb begin
    rise    = env.gate & ~gate_q;
    fall    = ~env.gate & gate_q;
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = ST_ATTACK;
    end else if (fall && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      state_d = ST_RELEASE;
    end else if (tick) begin
      case (state_q)
        ST_ATTACK: begin
          level_d = add_sat(level_q, env.attack_rate);
          if (level_d == LEVEL_MAX) state_d = ST_DECAY;
        end
        ST_DECAY: begin
          level_d = sub_floor(level_q, env.decay_rate, env.sustain_lvl);
          if (level_d == env.sustain_lvl) state_d = ST_SUSTAIN;
        end
        ST_SUSTAIN: level_d = env.sustain_lvl;
        ST_RELEASE: begin
          level_d = sub_floor(level_q, env.release_rate, '0);
          if (level_d == '0) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

`ifdef ADSR_ENV_PWM_EN
  logic pwm_q, pwm_d;
  assign pwm_d = (cnt < level_q);
  assign pwm_o = pwm_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ADSR_ENV_PWM_EN
      pwm_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= env.gate;
      busy_q  <= busy_d;
`ifdef ADSR_ENV_PWM_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign env.duty_cycle = level_q;
  assign env.env_state  = state_q;
  assign env.busy       = busy_q;

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env (TICK_DIV=1): reset, instant rates, ramps, release,
// retrigger and edge/tick collisions; PWM checks when ADSR_ENV_PWM_EN is defined.
module tb_adsr_env;
  import adsr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   ncyc;

  always #5 clk = ~clk;

  adsr_env_if env_if ();

`ifdef ADSR_ENV_PWM_EN
  logic pwm_o;
  adsr_env #(.TICK_DIV(1)) dut (.clk(clk), .rst(rst), .env(env_if), .pwm_o(pwm_o));
`else
  adsr_env #(.TICK_DIV(1)) dut (.clk(clk), .rst(rst), .env(env_if));
`endif

  // Bench-side clock count since reset release; ticks land on edges 256k+1, k>=1.
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns 1 time unit after the next edge whose count is phase mod 256.
  task automatic wait_phase(input int phase);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (ncyc >= 256 && (ncyc % 256) == phase) hit = 1'b1;
    end
    if (!hit) chk("phase_timeout", 0, 1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int duty, input int st);
    chk({tag, "_duty"}, int'(env_if.duty_cycle), duty);
    chk({tag, "_state"}, int'(env_if.env_state), st);
  endtask

  initial begin
    env_if.gate         = 1'b1;
    env_if.attack_rate  = 4'd0;
    env_if.decay_rate   = 4'd0;
    env_if.sustain_lvl  = 8'd128;
    env_if.release_rate = 4'd0;
    #12;
    chk_out("in_reset", 0, 0);
    chk("in_reset_busy", int'(env_if.busy), 0);

    // gate held high across reset release counts as a rising edge
    release_rst();
    @(posedge clk); #1;
    chk_out("first_clk_rise", 0, 1);
    chk("first_clk_busy", int'(env_if.busy), 1);
    wait_phase(1);
    chk_out("instant_attack", 255, 2);
    wait_phase(1);
    chk_out("instant_decay", 128, 3);
    env_if.sustain_lvl = 8'd100;
    wait_phase(1);
    chk_out("sustain_track", 100, 3);
    env_if.sustain_lvl = 8'd128;
    wait_phase(1);
    chk_out("sustain_128", 128, 3);
    #1 rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0);
    chk("async_rst_busy", int'(env_if.busy), 0);

    // attack ramp of 15 per tick, then slow decay
    env_if.gate        = 1'b0;
    env_if.attack_rate = 4'd15;
    env_if.decay_rate  = 4'd1;
    env_if.sustain_lvl = 8'd200;
    release_rst();
    @(posedge clk); #1;
    env_if.gate = 1'b1;
    @(posedge clk); #1;
    chk_out("ramp_start", 0, 1);
    for (int k = 1; k <= 17; k++) begin
      wait_phase(1);
      chk_out($sformatf("ramp_%0d", k), 15 * k, (k < 17) ? 1 : 2);
    end
    wait_phase(1);
    chk_out("decay_step", 254, 2);
    env_if.decay_rate  = 4'd0;
    env_if.sustain_lvl = 8'd60;
    wait_phase(1);
    chk_out("decay_instant", 60, 3);

    // release 60 -> 0 in steps of 4
    env_if.release_rate = 4'd4;
    env_if.gate         = 1'b0;
    @(posedge clk); #1;
    chk_out("rel_enter", 60, 4);
    for (int k = 1; k <= 15; k++) begin
      wait_phase(1);
      chk_out($sformatf("rel_%0d", k), 60 - 4 * k, (k < 15) ? 4 : 0);
    end
    chk("rel_busy", int'(env_if.busy), 0);
    wait_phase(1);
    chk_out("idle_tick", 0, 0);

    // build up to RELEASE at level 40, then retrigger
    env_if.attack_rate = 4'd0;
    env_if.sustain_lvl = 8'd40;
    env_if.gate        = 1'b1;
    wait_phase(1);
    chk_out("rt_attack", 255, 2);
    wait_phase(1);
    chk_out("rt_sustain", 40, 3);
    env_if.gate = 1'b0;
    @(posedge clk); #1;
    chk_out("rt_release", 40, 4);
    env_if.gate        = 1'b1;
    env_if.attack_rate = 4'd5;
    @(posedge clk); #1;
    chk_out("rt_retrig", 40, 1);
    wait_phase(1);
    chk_out("rt_ramp", 45, 1);

    // gate edges landing exactly on the tick edge hold the level
    wait_phase(0);
    env_if.gate = 1'b0;
    @(posedge clk); #1;
    chk_out("coll_fall", 45, 4);
    wait_phase(1);
    chk_out("coll_fall_next", 41, 4);
    wait_phase(0);
    env_if.gate = 1'b1;
    @(posedge clk); #1;
    chk_out("coll_rise", 41, 1);
    wait_phase(1);
    chk_out("coll_rise_next", 46, 1);

`ifdef ADSR_ENV_PWM_EN
    begin
      int highs;
      rst                 = 1'b1;
      env_if.gate         = 1'b0;
      env_if.attack_rate  = 4'd0;
      env_if.decay_rate   = 4'd0;
      env_if.sustain_lvl  = 8'd64;
      #1;
      chk("pwm_rst", int'(pwm_o), 0);
      release_rst();
      @(posedge clk); #1;
      env_if.gate = 1'b1;
      wait_phase(1);
      wait_phase(1);
      chk_out("pwm_duty64", 64, 3);
      wait_phase(2);
      highs = 0;
      repeat (256) begin
        @(posedge clk); #1;
        highs += int'(pwm_o);
      end
      chk("pwm_high_64", highs, 64);
      rst         = 1'b1;
      env_if.gate = 1'b0;
      release_rst();
      highs = 0;
      repeat (300) begin
        @(posedge clk); #1;
        highs += int'(pwm_o);
      end
      chk("pwm_high_0", highs, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
